// File: rtl/cmp_rr_arbiter_pkg.sv
// Shared defaults and helpers for the round-robin arbitrated magnitude comparator.
package cmp_rr_arbiter_pkg;

    localparam int  DEF_WIDTH     = 16;
    localparam int  DEF_NREQ      = 4;
    localparam logic MODE_UNSIGNED = 1'b1;

    // Index width for n requesters, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/cmp_rr_arbiter_rr_pick.sv
// Round-robin pick: scans requesters starting after the last grant, with wrap.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id,
    output logic            any
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant = '0;
        id    = '0;
        any   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = int'(last) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any && valid[j]) begin
                grant[j] = 1'b1;
                id       = IDW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/comparator.sv
// Flag comparator: reduces subtract flags N, C, V to a less-than result.
module comparator (
    input  logic n,
    input  logic c,
    input  logic v,
    input  logic bool0,
    output logic lt
);

    // Unsigned A<B is a borrow (no carry out); signed A<B is N xor V.
    assign lt = bool0 ? ~c : (n ^ v);

endmodule

// File: rtl/cmp_rr_arbiter.sv
// Round-robin shared two-stage less-than compare unit; results return one-hot to the issuer.
module cmp_rr_arbiter
    import cmp_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = clog2_min1(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_unsigned,
    output logic [NREQ-1:0]       rsp_valid,
    output logic                  rsp_lt,
    output logic [IDW-1:0]        rsp_id
);

    logic [IDW-1:0]   last;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   pick_id;
    logic             pick_any;
    logic             accept;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_uns;
    logic [IDW-1:0]   s1_id;

    logic             flag_c;
    logic             flag_n;
    logic             flag_v;
    logic             lt;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid (req_valid),
        .last  (last),
        .grant (grant),
        .id    (pick_id),
        .any   (pick_any)
    );

    assign req_ready = rst ? '0 : grant;
    assign accept    = pick_any & ~rst;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s1_valid <= 1'b0;
            last     <= IDW'(NREQ - 1);
        end else begin
            s1_valid <= accept;
            if (accept) begin
                last <= pick_id;
            end
        end
    end

    // NOTE: operand registers carry no reset; s1_valid alone qualifies them.
    // Loading only on accept keeps non-granted (possibly X) operands out of the pipe.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a   <= req_a[pick_id*WIDTH +: WIDTH];
            s1_b   <= req_b[pick_id*WIDTH +: WIDTH];
            s1_uns <= req_unsigned[pick_id];
            s1_id  <= pick_id;
        end
    end

    // A - B as A + ~B + 1; only the carry out and sign bit are needed.
    assign {flag_c, flag_n} = 2'(({1'b0, s1_a} + {1'b0, ~s1_b} + (WIDTH+1)'(1)) >> (WIDTH - 1));
    assign flag_v = (s1_a[WIDTH-1] ^ s1_b[WIDTH-1]) & (s1_a[WIDTH-1] ^ flag_n);

    comparator u_cmp (
        .n     (flag_n),
        .c     (flag_c),
        .v     (flag_v),
        .bool0 (s1_uns == MODE_UNSIGNED),
        .lt    (lt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_lt    <= 1'b0;
            rsp_id    <= '0;
        end else begin
            rsp_valid <= s1_valid ? (NREQ'(1) << s1_id) : '0;
            if (s1_valid) begin
                rsp_lt <= lt;
                rsp_id <= s1_id;
            end
        end
    end

endmodule

// File: tb/tb_cmp_rr_arbiter.sv
// Randomized self-checking bench for cmp_rr_arbiter against a cycle-level reference model.
module tb_cmp_rr_arbiter;

    localparam int W  = 16;
    localparam int NR = 4;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*W-1:0] req_a;
    logic [NR*W-1:0] req_b;
    logic [NR-1:0]   req_unsigned;
    logic [NR-1:0]   rsp_valid;
    logic            rsp_lt;
    logic [1:0]      rsp_id;

    cmp_rr_arbiter #(.WIDTH(W), .NREQ(NR)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_lt       (rsp_lt),
        .rsp_id       (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int id;
        bit lt;
    } ent_t;

    int total = 0;
    int bad   = 0;

    // Model state: pending requests, held operands, pointer, two-deep response pipe.
    bit         pend [NR];
    bit [W-1:0] opa  [NR];
    bit [W-1:0] opb  [NR];
    bit         opu  [NR];
    int         last = NR - 1;
    ent_t       pipe [2];
    bit         rand_en   = 0;
    bit         keep_busy = 0;
    int         obs_grant;
    int         seen_rsps = 0;
    int         exp_rsps  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_lt(input bit [W-1:0] a, input bit [W-1:0] b, input bit uns);
        if (uns) return int'(a) < int'(b);
        return $signed(a) < $signed(b);
    endfunction

    function automatic int model_pick(input int from);
        for (int k = 1; k <= NR; k++) begin
            if (pend[(from + k) % NR]) return (from + k) % NR;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit [W-1:0] a, input bit [W-1:0] b, input bit uns);
        pend[i] = 1'b1;
        opa[i]  = a;
        opb[i]  = b;
        opu[i]  = uns;
    endtask

    task automatic new_op(input int i);
        bit [W-1:0] a, b;
        int sel;
        a   = W'($urandom);
        b   = W'($urandom);
        sel = $urandom_range(0, 9);
        if (sel == 0) b = a;
        if (sel == 1) begin a = 16'h8000; b = 16'h7FFF; end
        if (sel == 2) begin a = 16'h7FFF; b = 16'h8000; end
        set_req(i, a, b, 1'($urandom));
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]       = pend[i];
            req_a[i*W +: W]    = pend[i] ? opa[i] : W'($urandom);
            req_b[i*W +: W]    = pend[i] ? opb[i] : W'($urandom);
            req_unsigned[i]    = pend[i] ? opu[i] : 1'($urandom);
        end
    endtask

    // One clock cycle: check at negedge, advance the model at posedge.
    task automatic step();
        int          pick;
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] exp_rv;
        ent_t        cur;
        drive();
        @(negedge clk);
        pick      = model_pick(last);
        exp_ready = '0;
        if (!rst && pick >= 0) exp_ready[pick] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        obs_grant = -1;
        for (int i = 0; i < NR; i++) if (req_ready[i]) obs_grant = i;
        exp_rv = '0;
        if (pipe[0].v) exp_rv[pipe[0].id] = 1'b1;
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (pipe[0].v) begin
            check("rsp_lt", 32'(rsp_lt), 32'(pipe[0].lt));
            check("rsp_id", 32'(rsp_id), 32'(pipe[0].id));
            exp_rsps++;
        end
        if (|rsp_valid) seen_rsps++;
        cur.v  = !rst && pick >= 0;
        cur.id = (pick >= 0) ? pick : 0;
        cur.lt = (pick >= 0) ? ref_lt(opa[cur.id], opb[cur.id], opu[cur.id]) : 1'b0;
        @(posedge clk);
        if (rst) begin
            last    = NR - 1;
            pipe[0] = '{v: 1'b0, id: 0, lt: 1'b0};
            pipe[1] = '{v: 1'b0, id: 0, lt: 1'b0};
        end else begin
            pipe[0] = pipe[1];
            pipe[1] = cur;
            if (cur.v) begin
                last = pick;
                if (keep_busy) new_op(pick);
                else pend[pick] = 1'b0;
            end
        end
        #1;
        if (rand_en) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 40) new_op(i);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        int prev;
        for (int i = 0; i < NR; i++) begin
            pend[i] = 1'b1;
            opa[i]  = '0;
            opb[i]  = '0;
            opu[i]  = 1'b0;
        end
        pipe[0] = '{v: 1'b0, id: 0, lt: 1'b0};
        pipe[1] = '{v: 1'b0, id: 0, lt: 1'b0};
        rst = 1'b1;
        drive();
        @(posedge clk);
        #1;

        // Reset with all requesters valid: ready must stay low.
        step();
        step();
        rst = 1'b0;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_lt", 32'(rsp_lt), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        step();

        // Single unsigned 5 < 9 from requester 0.
        set_req(0, 16'd5, 16'd9, 1'b1);
        drain();

        // Signed overflow and equality boundaries.
        set_req(0, 16'h8000, 16'h7FFF, 1'b0);
        set_req(1, 16'h8000, 16'h7FFF, 1'b1);
        set_req(2, 16'h1234, 16'h1234, 1'b0);
        set_req(3, 16'h1234, 16'h1234, 1'b1);
        for (int i = 0; i < 6; i++) step();

        // All valid continuously: grants rotate with no bubbles.
        keep_busy = 1;
        for (int i = 0; i < NR; i++) new_op(i);
        step();
        prev = obs_grant;
        for (int i = 1; i < 8; i++) begin
            step();
            check("rotate", 32'(obs_grant), 32'((prev + 1) % NR));
            prev = obs_grant;
        end
        keep_busy = 0;
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        drain();

        // Pointer at 1, then requesters 1 and 3 compete: 3 first, then 1.
        set_req(1, 16'd100, 16'd7, 1'b1);
        drain();
        set_req(1, 16'hFFFF, 16'h0001, 1'b0);
        set_req(3, 16'hFFFF, 16'h0001, 1'b1);
        step();
        check("grant_3_first", 32'(obs_grant), 32'd3);
        step();
        check("grant_1_next", 32'(obs_grant), 32'd1);
        drain();

        // Reset while operations are in flight drops them.
        set_req(2, 16'd1, 16'd2, 1'b1);
        step();
        set_req(1, 16'd3, 16'd4, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        step();
        check("no_rsp_after_rst_a", 32'(rsp_valid), 32'd0);
        step();
        check("no_rsp_after_rst_b", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < NR; i++) new_op(i);
        step();
        check("ptr_after_rst", 32'(obs_grant), 32'd0);
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        drain();

        // Randomized traffic.
        rand_en = 1;
        for (int i = 0; i < 2000; i++) step();
        rand_en = 0;
        for (int i = 0; i < 12; i++) step();
        for (int i = 0; i < NR; i++) check("no_lost_request", 32'(pend[i]), 32'd0);
        check("rsp_count", 32'(seen_rsps), 32'(exp_rsps));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
